// File: rtl/spi_master_multi_if.sv
// Signal bundle for spi_master_multi: configuration, word handshake and SPI pins.
// The master modport is the controller's view; slave is the attached system/bench.
interface spi_master_multi_if #(
   parameter int DATA_WIDTH = 8,
   parameter int CS_COUNT   = 4,
   parameter int DIV_WIDTH  = 16
);
   localparam int SEL_W = $clog2(CS_COUNT) + 1;

   logic [DIV_WIDTH-1:0]  cfg_clock_div;
   logic                  cfg_cpol;
   logic                  cfg_cpha;
   logic                  cfg_msb_first;
   logic [SEL_W-1:0]      cfg_cs_select;
   logic                  cfg_cs_auto;
   logic                  cfg_cs_manual;
   logic                  cfg_loopback;
   logic [DATA_WIDTH-1:0] tx_data;
   logic                  tx_valid;
   logic                  tx_ready;
   logic [DATA_WIDTH-1:0] rx_data;
   logic                  rx_valid;
   logic                  busy;
   logic                  sck;
   logic                  mosi;
   logic                  miso;
   logic [CS_COUNT-1:0]   cs_n;

   modport master (
      input  cfg_clock_div, cfg_cpol, cfg_cpha, cfg_msb_first, cfg_cs_select,
             cfg_cs_auto, cfg_cs_manual, cfg_loopback, tx_data, tx_valid, miso,
      output tx_ready, rx_data, rx_valid, busy, sck, mosi, cs_n
   );

   modport slave (
      output cfg_clock_div, cfg_cpol, cfg_cpha, cfg_msb_first, cfg_cs_select,
             cfg_cs_auto, cfg_cs_manual, cfg_loopback, tx_data, tx_valid, miso,
      input  tx_ready, rx_data, rx_valid, busy, sck, mosi, cs_n
   );
endinterface

// File: rtl/spi_master_multi.sv
// Multi-device SPI master: one word per transfer, all four modes, either bit order.
// Optional MOSI->MISO loopback is compiled in with SPI_MASTER_MULTI_LOOPBACK_EN.
module spi_master_multi #(
   parameter int DATA_WIDTH = 8,
   parameter int CS_COUNT   = 4,
   parameter int DIV_WIDTH  = 16
) (
   input logic                clk,
   input logic                rst_n,
   spi_master_multi_if.master bus
);
   localparam int SEL_W  = $clog2(CS_COUNT) + 1;
   localparam int HALF_W = $clog2(2 * DATA_WIDTH) + 1;
   localparam logic [HALF_W-1:0] LAST_HALF = HALF_W'(2 * DATA_WIDTH - 1);

   typedef enum logic [1:0] {IDLE, CS_SETUP, SHIFT, CS_HOLD} state_t;

   state_t                state_q;
   logic                  armed_q;
   logic [DIV_WIDTH-1:0]  div_q;
   logic [DIV_WIDTH-1:0]  cnt_q;
   logic [HALF_W-1:0]     half_q;
   logic                  cpha_q;
   logic                  msb_q;
   logic                  auto_q;
   logic [SEL_W-1:0]      sel_q;
   logic [DATA_WIDTH-1:0] tx_sh_q;
   logic [DATA_WIDTH-1:0] rx_sh_q;
   logic [DATA_WIDTH-1:0] rx_data_q;
   logic                  rx_valid_q;
   logic                  sck_q;
   logic                  mosi_q;

   logic                  idle;
   logic                  accept;
   logic                  half_end;
   logic                  sample;
   logic                  advance;
   logic                  rx_bit;
   logic [DATA_WIDTH-1:0] rx_sh_d;
   logic                  eff_auto;
   logic [SEL_W-1:0]      eff_sel;
   logic [CS_COUNT-1:0]   cs_n_d;

   function automatic logic first_bit(input logic [DATA_WIDTH-1:0] w, input logic msb);
      return msb ? w[DATA_WIDTH-1] : w[0];
   endfunction

   function automatic logic [DATA_WIDTH-1:0] shift_out(input logic [DATA_WIDTH-1:0] w,
                                                       input logic msb);
      return msb ? {w[DATA_WIDTH-2:0], 1'b0} : {1'b0, w[DATA_WIDTH-1:1]};
   endfunction

   assign idle     = (state_q == IDLE);
   assign accept   = idle && armed_q && bus.tx_valid;
   assign half_end = (cnt_q == '0);
   // Even half-periods end on a leading sck edge; cpha picks which edge samples.
   assign sample   = (~half_q[0]) ^ cpha_q;
   assign advance  = ~sample && (half_q != LAST_HALF);
   assign rx_sh_d  = msb_q ? {rx_sh_q[DATA_WIDTH-2:0], rx_bit}
                           : {rx_bit, rx_sh_q[DATA_WIDTH-1:1]};

`ifdef SPI_MASTER_MULTI_LOOPBACK_EN
   logic lb_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      lb_q <= 1'b0;
      else if (accept) lb_q <= bus.cfg_loopback;
   end
   assign rx_bit = lb_q ? mosi_q : bus.miso;
`else
   logic unused_loopback;
   assign unused_loopback = bus.cfg_loopback;
   assign rx_bit          = bus.miso;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         armed_q    <= 1'b0;
         div_q      <= '0;
         cnt_q      <= '0;
         half_q     <= '0;
         cpha_q     <= 1'b0;
         msb_q      <= 1'b0;
         auto_q     <= 1'b0;
         sel_q      <= '0;
         tx_sh_q    <= '0;
         rx_sh_q    <= '0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         sck_q      <= 1'b0;
         mosi_q     <= 1'b0;
      end else begin
         armed_q    <= 1'b1;
         rx_valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (accept) begin
                  state_q <= CS_SETUP;
                  div_q   <= bus.cfg_clock_div;
                  cnt_q   <= bus.cfg_clock_div;
                  half_q  <= '0;
                  cpha_q  <= bus.cfg_cpha;
                  msb_q   <= bus.cfg_msb_first;
                  auto_q  <= bus.cfg_cs_auto;
                  sel_q   <= bus.cfg_cs_select;
                  sck_q   <= bus.cfg_cpol;
                  rx_sh_q <= '0;
                  if (!bus.cfg_cpha) begin
                     mosi_q  <= first_bit(bus.tx_data, bus.cfg_msb_first);
                     tx_sh_q <= shift_out(bus.tx_data, bus.cfg_msb_first);
                  end else begin
                     mosi_q  <= 1'b0;
                     tx_sh_q <= bus.tx_data;
                  end
               end
            end
            CS_SETUP: begin
               if (half_end) begin
                  state_q <= SHIFT;
                  cnt_q   <= div_q;
               end else begin
                  cnt_q <= cnt_q - DIV_WIDTH'(1);
               end
            end
            SHIFT: begin
               if (half_end) begin
                  cnt_q  <= div_q;
                  sck_q  <= ~sck_q;
                  half_q <= half_q + HALF_W'(1);
                  if (sample) rx_sh_q <= rx_sh_d;
                  if (advance) begin
                     mosi_q  <= first_bit(tx_sh_q, msb_q);
                     tx_sh_q <= shift_out(tx_sh_q, msb_q);
                  end
                  // With cpha=1 the final sample lands on this same edge.
                  if (half_q == LAST_HALF) begin
                     state_q    <= CS_HOLD;
                     rx_data_q  <= sample ? rx_sh_d : rx_sh_q;
                     rx_valid_q <= 1'b1;
                  end
               end else begin
                  cnt_q <= cnt_q - DIV_WIDTH'(1);
               end
            end
            CS_HOLD: begin
               if (half_end) begin
                  state_q <= IDLE;
                  mosi_q  <= 1'b0;
               end else begin
                  cnt_q <= cnt_q - DIV_WIDTH'(1);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Live configuration steers the idle pins; the latched copy holds during a transfer.
   always_comb begin
      eff_auto = idle ? bus.cfg_cs_auto : auto_q;
      eff_sel  = idle ? bus.cfg_cs_select : sel_q;
      cs_n_d   = '1;
      for (int unsigned i = 0; i < CS_COUNT; i++) begin
         if (32'(eff_sel) == i) cs_n_d[i] = eff_auto ? idle : ~bus.cfg_cs_manual;
      end
      if (!rst_n) cs_n_d = '1;
   end

   assign bus.cs_n     = cs_n_d;
   assign bus.sck      = idle ? (rst_n & bus.cfg_cpol) : sck_q;
   assign bus.mosi     = mosi_q;
   assign bus.tx_ready = idle && armed_q;
   assign bus.busy     = ~idle;
   assign bus.rx_data  = rx_data_q;
   assign bus.rx_valid = rx_valid_q;
endmodule

// File: tb/tb_spi_master_multi.sv
// Self-checking bench for spi_master_multi: a behavioural SPI slave plus
// directed and randomized word transfers, a mid-transfer reset and a 16-bit instance.
module tb_spi_master_multi;
   logic clk = 1'b0;
   logic rst_n;
   int   n_tests = 0;
   int   n_fail  = 0;
   int   rxv_total = 0;

   always #5 clk = ~clk;

   spi_master_multi_if #(.DATA_WIDTH(8), .CS_COUNT(4), .DIV_WIDTH(16)) bus ();
   spi_master_multi_if #(.DATA_WIDTH(16), .CS_COUNT(4), .DIV_WIDTH(3)) bus16 ();

   spi_master_multi #(.DATA_WIDTH(8), .CS_COUNT(4), .DIV_WIDTH(16)) u_dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );
   spi_master_multi #(.DATA_WIDTH(16), .CS_COUNT(4), .DIV_WIDTH(3)) u_dut16 (
      .clk(clk), .rst_n(rst_n), .bus(bus16)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic int bp(input int k, input bit msb);
      return msb ? 7 - k : k;
   endfunction

   function automatic logic [3:0] exp_cs(input bit in_xfer, input bit auto_m,
                                         input bit manual, input int sel);
      logic [3:0] v;
      v = '1;
      if (sel < 4) v[sel] = auto_m ? !in_xfer : !manual;
      return v;
   endfunction

   // Behavioural slave: shifts out s_word and collects mosi into s_rx.
   logic [7:0] s_word = '0;
   logic [7:0] s_rx;
   bit         s_cpol, s_cpha, s_msb;
   logic       s_busy_q = 1'b0;
   logic       s_sck_q = 1'b0;
   int         s_txk, s_rxk;

   always @(negedge clk) begin
      s_busy_q <= bus.busy;
      s_sck_q  <= bus.sck;
      if (bus.rx_valid) rxv_total <= rxv_total + 1;
      if (!rst_n) begin
         bus.miso <= 1'b0;
      end else if (bus.busy && !s_busy_q) begin
         s_txk <= 0;
         s_rxk <= 0;
         s_rx  <= '0;
         if (!s_cpha) begin
            bus.miso <= s_word[bp(0, s_msb)];
            s_txk    <= 1;
         end
      end else if (bus.busy && (bus.sck != s_sck_q)) begin
         if ((s_sck_q == s_cpol) ^ s_cpha) begin
            if (s_rxk < 8) s_rx[bp(s_rxk, s_msb)] <= bus.mosi;
            s_rxk <= s_rxk + 1;
         end else begin
            if (s_txk < 8) bus.miso <= s_word[bp(s_txk, s_msb)];
            s_txk <= s_txk + 1;
         end
      end
   end

   task automatic do_xfer(input logic [7:0] tx, input logic [7:0] sw, input bit cpol,
                          input bit cpha, input bit msb, input int div, input int sel,
                          input bit auto_m, input bit manual, input bit lb, input bit scr,
                          input string tag);
      int h, wait_n, busy_n, toggles, gap, bad_gap, cs_bad, rdy_bad, rxv_n;
      logic [7:0] rxd, exp_rx;
      logic prev_sck;
      h = div + 1;
      wait_n = 0; busy_n = 0; toggles = 0; gap = 0; bad_gap = 0;
      cs_bad = 0; rdy_bad = 0; rxv_n = 0; rxd = 'x;
`ifdef SPI_MASTER_MULTI_LOOPBACK_EN
      exp_rx = lb ? tx : sw;
`else
      exp_rx = sw;
`endif
      @(negedge clk);
      s_word = sw; s_cpol = cpol; s_cpha = cpha; s_msb = msb;
      bus.cfg_clock_div = 16'(div);
      bus.cfg_cpol = cpol; bus.cfg_cpha = cpha; bus.cfg_msb_first = msb;
      bus.cfg_cs_select = 3'(sel); bus.cfg_cs_auto = auto_m; bus.cfg_cs_manual = manual;
      bus.cfg_loopback = lb; bus.tx_data = tx; bus.tx_valid = 1'b1;
      while (!bus.tx_ready && wait_n < 100) begin
         @(negedge clk);
         wait_n++;
      end
      check({tag, "_ready"}, 32'(bus.tx_ready), 1);
      @(posedge clk);
      @(negedge clk);
      bus.tx_valid = 1'b0;
      if (scr) begin
         bus.cfg_clock_div = 16'($urandom);
         bus.cfg_cpol = 1'($urandom); bus.cfg_cpha = 1'($urandom);
         bus.cfg_msb_first = 1'($urandom); bus.cfg_loopback = 1'($urandom);
         bus.tx_data = 8'($urandom);
      end
      check({tag, "_sck_start"}, 32'(bus.sck), 32'(cpol));
      prev_sck = bus.sck;
      while (bus.busy && busy_n < 5000) begin
         busy_n++;
         if (bus.cs_n !== exp_cs(1, auto_m, manual, sel)) cs_bad++;
         if (bus.tx_ready !== 1'b0) rdy_bad++;
         if (bus.rx_valid) begin
            rxv_n++;
            rxd = bus.rx_data;
         end
         if (bus.sck != prev_sck) begin
            toggles++;
            if (toggles > 1 && gap != h) bad_gap++;
            gap = 0;
         end
         gap++;
         prev_sck = bus.sck;
         @(negedge clk);
      end
      check({tag, "_busy_cycles"}, 32'(busy_n), 32'(2 * h + 16 * h));
      check({tag, "_rx_valid_n"}, 32'(rxv_n), 1);
      check({tag, "_rx_data"}, 32'(rxd), 32'(exp_rx));
      check({tag, "_rx_hold"}, 32'(bus.rx_data), 32'(exp_rx));
      check({tag, "_slave_rx"}, 32'(s_rx), 32'(tx));
      check({tag, "_sck_toggles"}, 32'(toggles), 16);
      check({tag, "_sck_half"}, 32'(bad_gap), 0);
      check({tag, "_cs_xfer"}, 32'(cs_bad), 0);
      check({tag, "_ready_busy"}, 32'(rdy_bad), 0);
      check({tag, "_mosi_idle"}, 32'(bus.mosi), 0);
      check({tag, "_sck_idle"}, 32'(bus.sck), 32'(bus.cfg_cpol));
      check({tag, "_cs_idle"}, 32'(bus.cs_n), 32'(exp_cs(0, auto_m, manual, sel)));
   endtask

   initial begin
      int cnt, tg, k, rxv_before;
      logic prev;
      logic [15:0] cap, rxd16;
      rst_n = 1'b0;
      bus.cfg_clock_div = '0; bus.cfg_cpol = 1'b0; bus.cfg_cpha = 1'b0;
      bus.cfg_msb_first = 1'b1; bus.cfg_cs_select = '0; bus.cfg_cs_auto = 1'b1;
      bus.cfg_cs_manual = 1'b0; bus.cfg_loopback = 1'b0; bus.tx_data = '0; bus.tx_valid = 1'b0;
      bus16.cfg_clock_div = '0; bus16.cfg_cpol = 1'b0; bus16.cfg_cpha = 1'b0;
      bus16.cfg_msb_first = 1'b0; bus16.cfg_cs_select = '0; bus16.cfg_cs_auto = 1'b1;
      bus16.cfg_cs_manual = 1'b0; bus16.cfg_loopback = 1'b0; bus16.tx_data = '0;
      bus16.tx_valid = 1'b0; bus16.miso = 1'b1;
      #1;
      check("rst_cs_n", 32'(bus.cs_n), 32'hF);
      check("rst_sck", 32'(bus.sck), 0);
      check("rst_mosi", 32'(bus.mosi), 0);
      check("rst_busy", 32'(bus.busy), 0);
      check("rst_tx_ready", 32'(bus.tx_ready), 0);
      check("rst_rx_data", 32'(bus.rx_data), 0);
      check("rst_rx_valid", 32'(bus.rx_valid), 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rel_ready_pre", 32'(bus.tx_ready), 0);
      @(posedge clk);
      #1;
      check("rel_ready_post", 32'(bus.tx_ready), 1);

      do_xfer(8'h1F, 8'hC5, 0, 0, 1, 7, 0, 1, 0, 0, 0, "mode0");
      do_xfer(8'h83, 8'h1F, 1, 1, 1, 3, 1, 1, 0, 0, 0, "mode3");
      do_xfer(8'h5A, 8'h3C, 0, 1, 0, 0, 3, 1, 0, 0, 0, "mode1_div0");
      do_xfer(8'hE1, 8'h96, 1, 0, 0, 2, 2, 1, 0, 0, 0, "mode2_lsb");
      do_xfer(8'h12, 8'hAB, 0, 0, 1, 1, 2, 0, 1, 0, 0, "man_a");
      do_xfer(8'h34, 8'hCD, 0, 0, 1, 1, 2, 0, 1, 0, 0, "man_b");
      do_xfer(8'h77, 8'h88, 0, 0, 1, 1, 5, 0, 1, 0, 0, "man_sel5");
      do_xfer(8'hC3, 8'h5E, 1, 0, 1, 0, 4, 1, 0, 0, 0, "auto_sel4");
      do_xfer(8'h9B, 8'h00, 0, 0, 1, 2, 0, 1, 0, 1, 0, "loopback");
      for (int i = 0; i < 30; i++) begin
         do_xfer(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 5)), 1'($urandom),
                 1'($urandom), 1'($urandom), 1, "rand");
      end

      // Abort a mode-3 transfer in its fourth bit.
      @(negedge clk);
      s_word = 8'h66; s_cpol = 1; s_cpha = 1; s_msb = 1;
      bus.cfg_clock_div = 16'd1; bus.cfg_cpol = 1'b1; bus.cfg_cpha = 1'b1;
      bus.cfg_msb_first = 1'b1; bus.cfg_cs_select = 3'd1; bus.cfg_cs_auto = 1'b1;
      bus.cfg_cs_manual = 1'b0; bus.cfg_loopback = 1'b0; bus.tx_data = 8'hA5;
      bus.tx_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.tx_valid = 1'b0;
      rxv_before = rxv_total;
      cnt = 0; tg = 0; prev = bus.sck;
      while (tg < 6 && cnt < 1000) begin
         @(negedge clk);
         cnt++;
         if (bus.sck != prev) tg++;
         prev = bus.sck;
      end
      check("abort_reach_bit3", 32'(tg), 6);
      rst_n = 1'b0;
      #1;
      check("abort_cs_n", 32'(bus.cs_n), 32'hF);
      check("abort_sck", 32'(bus.sck), 0);
      check("abort_mosi", 32'(bus.mosi), 0);
      check("abort_busy", 32'(bus.busy), 0);
      check("abort_tx_ready", 32'(bus.tx_ready), 0);
      check("abort_rx_data", 32'(bus.rx_data), 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (30) @(negedge clk);
      check("abort_no_rx_valid", 32'(rxv_total - rxv_before), 0);
      do_xfer(8'h3D, 8'hB2, 0, 0, 1, 1, 1, 1, 0, 0, 0, "after_abort");

      // 16-bit LSB-first word with an all-ones 3-bit divider (H = 8).
      @(negedge clk);
      bus16.cfg_clock_div = 3'b111; bus16.tx_data = 16'hA35C; bus16.tx_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus16.tx_valid = 1'b0;
      cnt = 0; k = 0; cap = '0; rxd16 = '0; prev = bus16.sck;
      while (bus16.busy && cnt < 2000) begin
         cnt++;
         if (bus16.rx_valid) rxd16 = bus16.rx_data;
         if (bus16.sck && !prev && k < 16) begin
            cap[k] = bus16.mosi;
            k++;
         end
         prev = bus16.sck;
         @(negedge clk);
      end
      check("w16_busy_cycles", 32'(cnt), 32'(2 * 8 + 32 * 8));
      check("w16_bits_seen", 32'(k), 16);
      check("w16_mosi_seq", 32'(cap), 32'hA35C);
      check("w16_rx_data", 32'(rxd16), 32'hFFFF);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
